// File: rtl/mult_seq_ctrl.sv
// Sequencer for an unsigned W x W shift-add multiply on an external 2W-bit
// high/low product register (high = accumulator, low = multiplier).
module mult_seq_ctrl #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2*W-1:0] prod_q,
  output logic           reg_clear,
  output logic           reg_loadh,
  output logic           reg_loadl,
  output logic [W-1:0]   reg_inh,
  output logic [W-1:0]   reg_inl,
  output logic           busy,
  output logic           done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic          reg_clear_q, reg_clear_d;

  logic [W-1:0]  lo, hi;
  logic [W:0]    sum;

  assign lo = prod_q[W-1:0];
  assign hi = prod_q[2*W-1:W];
  // Carry out of the add lands in the accumulator MSB after the shift.
  assign sum = {1'b0, hi} + {1'b0, (lo[0] ? mcand_q : {W{1'b0}})};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    reg_clear_d = reset;
    reg_loadh   = 1'b0;
    reg_loadl   = 1'b0;
    reg_inh     = '0;
    reg_inl     = '0;
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          reg_loadh = 1'b1;
          reg_loadl = 1'b1;
          reg_inl   = b;
          mcand_d   = a;
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        reg_loadh = 1'b1;
        reg_loadl = 1'b1;
        reg_inh   = sum[W:1];
        reg_inl   = {sum[0], lo[W-1:1]};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
    end
  end

  // Clear is a delayed copy of reset so the register never sees a comb path.
  always_ff @(posedge clk) reg_clear_q <= reg_clear_d;

  assign reg_clear = reg_clear_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: W=8 and W=4 instances, each closing the loop
// through a behavioural high/low product register.
module tb_mult_seq_ctrl;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset, start, start4;
  logic [7:0]  a, b;
  logic [3:0]  a4, b4;

  logic        rc8, lh8, ll8, busy, done;
  logic [7:0]  ih8, il8;
  logic [15:0] prod8;
  logic        rc4, lh4, ll4, busy4, done4;
  logic [3:0]  ih4, il4;
  logic [7:0]  prod4;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.W(8)) u8 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .prod_q(prod8),
    .reg_clear(rc8), .reg_loadh(lh8), .reg_loadl(ll8), .reg_inh(ih8),
    .reg_inl(il8), .busy(busy), .done(done));

  mult_seq_ctrl #(.W(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .prod_q(prod4),
    .reg_clear(rc4), .reg_loadh(lh4), .reg_loadl(ll4), .reg_inh(ih4),
    .reg_inl(il4), .busy(busy4), .done(done4));

  always_ff @(posedge clk) begin
    if (rc8) prod8 <= '0;
    else begin
      if (lh8) prod8[15:8] <= ih8;
      if (ll8) prod8[7:0]  <= il8;
    end
  end

  always_ff @(posedge clk) begin
    if (rc4) prod4 <= '0;
    else begin
      if (lh4) prod4[7:4] <= ih4;
      if (ll4) prod4[3:0] <= il4;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: timing from accept-edge arithmetic, result from a*b.
  int          ecnt = 0, free_at = 0, op_t = 0, ndone = 0;
  bit          have_op = 0;
  logic [15:0] op_exp;
  int          done_edges[$];

  task automatic tick();
    logic s, r;
    logic [7:0] ai, bi;
    bit eb, ed;
    s = start; r = reset; ai = a; bi = b;
    @(posedge clk);
    ecnt++;
    if (r) begin
      have_op = 0;
      free_at = ecnt + 1;
    end else if (s && ecnt >= free_at) begin
      have_op = 1;
      op_t    = ecnt;
      op_exp  = 16'(int'(ai) * int'(bi));
      free_at = ecnt + W + 2;
    end
    @(negedge clk);
    eb = have_op && ecnt >= op_t && ecnt <= op_t + W;
    ed = have_op && ecnt == op_t + W;
    chk("busy", int'(busy), int'(eb));
    chk("done", int'(done), int'(ed));
    chk("reg_clear", int'(rc8), int'(r));
    if (ed) chk("prod_at_done", int'(prod8), int'(op_exp));
    if (done) begin
      ndone++;
      done_edges.push_back(ecnt);
    end
  endtask

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        input logic [15:0] exp);
    int n;
    bit got;
    logic [15:0] p;
    n = 0; got = 0; p = '0;
    a = ia; b = ib; start = 1'b1;
    tick();
    start = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (done) begin
        got = 1;
        p = prod8;
      end
    end
    chk("op_done_seen", int'(got), 1);
    chk("op_latency", n, W);
    chk("op_product", int'(p), int'(exp));
    tick();
    chk("busy_after_done", int'(busy), 0);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d0, ex;
    bit got;
    vecs[0] = '{8'd13,  8'd11,  16'd143};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 16'd0};
    vecs[3] = '{8'd200, 8'd0,   16'd0};
    vecs[4] = '{8'd1,   8'd1,   16'd1};
    vecs[5] = '{8'd128, 8'd2,   16'd256};

    reset = 1'b1; start = 1'b0; start4 = 1'b0;
    a = '0; b = '0; a4 = '0; b4 = '0;

    // Reset for two cycles
    tick();
    chk("rst_loadh", int'(lh8), 0);
    chk("rst_loadl", int'(ll8), 0);
    chk("rst_inh", int'(ih8), 0);
    chk("rst_inl", int'(il8), 0);
    tick();
    chk("rst_prod", int'(prod8), 0);
    reset = 1'b0;
    tick();
    tick();

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

    // start pulse during RUN is ignored
    d0 = ndone;
    a = 8'd3; b = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    a = 8'd9; b = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("ignored_start_dones", ndone - d0, 1);

    // start held high: back-to-back ops W+2 edges apart
    done_edges.delete();
    a = 8'd3; b = 8'd5; start = 1'b1;
    tick();
    a = 8'd9; b = 8'd9;
    repeat (20) tick();
    start = 1'b0;
    repeat (12) tick();
    chk("b2b_done_count", done_edges.size(), 3);
    if (done_edges.size() >= 2) chk("b2b_spacing", done_edges[1] - done_edges[0], W + 2);

    // reset mid-operation
    d0 = ndone;
    a = 8'd100; b = 8'd77; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("midrst_busy", int'(busy), 0);
    reset = 1'b0;
    tick();
    chk("midrst_prod_cleared", int'(prod8), 0);
    tick();
    chk("midrst_no_done", ndone - d0, 0);
    run_op(8'd100, 8'd77, 16'd7700);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 2) == 0);
      a = 8'($urandom());
      b = 8'($urandom());
      tick();
    end
    start = 1'b0;
    repeat (12) tick();

    // W=4 instance: exhaustive operands
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
        tick();
        start4 = 1'b0;
        got = 0;
        for (int k = 1; k <= 4; k++) begin
          tick();
          if (done4) got = (k == 4);
        end
        ex = x * y;
        chk("w4_done_timing", int'(got), 1);
        chk("w4_product", int'(prod4), ex);
        tick();
        chk("w4_idle", int'(busy4), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
